// File: rtl/x1_gram_arbiter_if.sv
// Bus bundle between the X1 GRAM arbiter and its surroundings: Z80 side,
// video fetch side and the single GRAM port.
interface x1_gram_arbiter_if #(
    parameter int AW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_wait_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_dout;
    logic          vid_valid;
    logic          vid_overrun;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din, vid_req, vid_addr, mem_dout,
        input  cpu_dout, cpu_wait_n, vid_dout, vid_valid, vid_overrun,
               mem_addr, mem_we, mem_din
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din, vid_req, vid_addr, mem_dout,
        output cpu_dout, cpu_wait_n, vid_dout, vid_valid, vid_overrun,
               mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/x1_gram_arbiter.sv
// Shares the single GRAM port between the Z80 and the video fetcher.
// Video has priority; a streak counter guarantees the CPU a slot after STARVE fetches.
module x1_gram_arbiter #(
    parameter int AW     = 16,
    parameter int STARVE = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    x1_gram_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_VID_A,
        S_VID_D,
        S_CPU_A,
        S_CPU_D,
        S_CPU_W
    } state_t;

    state_t        state_q, state_d;
    logic          vpend_q, vpend_d;
    logic [AW-1:0] vaddr_q, vaddr_d;
    logic          cpu_done_q, cpu_done_d;
    logic [2:0]    streak_q, streak_d;
    logic          vid_valid_q, vid_valid_d;
    logic          vid_overrun_q, vid_overrun_d;
    logic [7:0]    vid_dout_q, vid_dout_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_din_q, mem_din_d;

    logic cpu_elig;
    logic vid_grant;
    logic cpu_grant;
    logic streak_full;

    assign cpu_elig    = bus.cpu_req & ~cpu_done_q;
    assign streak_full = (streak_q == 3'(STARVE));

    always_comb begin
        state_d       = state_q;
        vpend_d       = vpend_q;
        vaddr_d       = vaddr_q;
        cpu_done_d    = cpu_done_q;
        streak_d      = streak_q;
        vid_valid_d   = 1'b0;
        vid_overrun_d = vid_overrun_q;
        vid_dout_d    = vid_dout_q;
        cpu_dout_d    = cpu_dout_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = mem_we_q;
        mem_din_d     = mem_din_q;
        vid_grant     = 1'b0;
        cpu_grant     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (vpend_q && !(cpu_elig && streak_full)) begin
                    state_d    = S_VID_A;
                    mem_addr_d = vaddr_q;
                    vid_grant  = 1'b1;
                end else if (cpu_elig) begin
                    cpu_grant  = 1'b1;
                    mem_addr_d = bus.cpu_addr;
                    if (bus.cpu_we) begin
                        state_d   = S_CPU_W;
                        mem_din_d = bus.cpu_din;
                        mem_we_d  = 1'b1;
                    end else begin
                        state_d = S_CPU_A;
                    end
                end
            end
            S_VID_A: state_d = S_VID_D;
            S_VID_D: begin
                vid_dout_d  = bus.mem_dout;
                vid_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_CPU_A: state_d = S_CPU_D;
            S_CPU_D: begin
                // Read data is captured even when the Z80 abandoned the cycle.
                cpu_dout_d = bus.mem_dout;
                cpu_done_d = bus.cpu_req;
                state_d    = S_IDLE;
            end
            S_CPU_W: begin
                mem_we_d   = 1'b0;
                cpu_done_d = bus.cpu_req;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!bus.cpu_req) begin
            cpu_done_d = 1'b0;
        end

        // A request landing on the grant cycle simply refills the latch.
        if (vid_grant) begin
            vpend_d = 1'b0;
        end
        if (bus.vid_req) begin
            vpend_d = 1'b1;
            vaddr_d = bus.vid_addr;
            if (vpend_q && !vid_grant) begin
                vid_overrun_d = 1'b1;
            end
        end

        if (!cpu_elig || cpu_grant) begin
            streak_d = 3'd0;
        end else if (vid_grant && !streak_full) begin
            streak_d = streak_q + 3'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vpend_q       <= 1'b0;
            vaddr_q       <= '0;
            cpu_done_q    <= 1'b0;
            streak_q      <= 3'd0;
            vid_valid_q   <= 1'b0;
            vid_overrun_q <= 1'b0;
            vid_dout_q    <= 8'd0;
            cpu_dout_q    <= 8'd0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_din_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            vpend_q       <= vpend_d;
            vaddr_q       <= vaddr_d;
            cpu_done_q    <= cpu_done_d;
            streak_q      <= streak_d;
            vid_valid_q   <= vid_valid_d;
            vid_overrun_q <= vid_overrun_d;
            vid_dout_q    <= vid_dout_d;
            cpu_dout_q    <= cpu_dout_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_din_q     <= mem_din_d;
        end
    end

    assign bus.cpu_wait_n  = ~cpu_elig;
    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.vid_dout    = vid_dout_q;
    assign bus.vid_valid   = vid_valid_q;
    assign bus.vid_overrun = vid_overrun_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_din     = mem_din_q;
endmodule

// File: tb/tb_x1_gram_arbiter.sv
// Directed bench for x1_gram_arbiter: cycle table for the basic paths plus
// hand sequences for starvation, overrun, abort and reset mid-write.
module tb_x1_gram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    x1_gram_arbiter_if #(.AW(16)) bus ();

    x1_gram_arbiter #(.AW(16), .STARVE(4)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    // GRAM model with one-cycle registered read
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [7:0]  cdin;
        logic        vreq;
        logic [15:0] vaddr;
        logic        e_wait_n;
        logic        e_mem_we;
        logic        e_vvalid;
        logic        chk_vdout;
        logic [7:0]  e_vdout;
        logic        chk_maddr;
        logic [15:0] e_maddr;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic creq, logic cwe, logic [15:0] caddr, logic [7:0] cdin,
                                logic vreq, logic [15:0] vaddr, logic e_wait_n, logic e_mem_we,
                                logic e_vvalid, logic chk_vdout, logic [7:0] e_vdout,
                                logic chk_maddr, logic [15:0] e_maddr);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cdin = cdin;
        v.vreq = vreq; v.vaddr = vaddr; v.e_wait_n = e_wait_n; v.e_mem_we = e_mem_we;
        v.e_vvalid = e_vvalid; v.chk_vdout = chk_vdout; v.e_vdout = e_vdout;
        v.chk_maddr = chk_maddr; v.e_maddr = e_maddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [15:0] caddr,
                         input logic [7:0] cdin, input logic vreq, input logic [15:0] vaddr);
        bus.cpu_req  = creq;
        bus.cpu_we   = cwe;
        bus.cpu_addr = caddr;
        bus.cpu_din  = cdin;
        bus.vid_req  = vreq;
        bus.vid_addr = vaddr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cpu_wait_n to release; leaves time at #1 after a posedge.
    task automatic wait_cpu(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (bus.cpu_wait_n) seen = 1'b1;
            next_cycle();
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int         vbefore;
        int         vn;
        int         vcnt;
        bit         cdone;
        logic [7:0] vseen [$];

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1234] = 8'hA5;
        for (int i = 0; i < 5; i++) ram[16'h2000 + i] = 8'h10 + 8'(i);
        ram[16'h3000] = 8'h33;
        ram[16'h3001] = 8'h44;
        ram[16'h4000] = 8'h77;

        vecs[0]  = mk(0, 0, 16'h0000, 8'h00, 1, 16'h1234, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[1]  = mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[2]  = mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 8'h00, 1, 16'h1234);
        vecs[3]  = mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[4]  = mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 0, 1, 1, 8'hA5, 0, 16'h0000);
        vecs[5]  = mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[6]  = mk(1, 1, 16'h0100, 8'h5A, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[7]  = mk(1, 1, 16'h0100, 8'h5A, 0, 16'h0000, 0, 1, 0, 0, 8'h00, 1, 16'h0100);
        vecs[8]  = mk(1, 1, 16'h0100, 8'h5A, 0, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[9]  = mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[10] = mk(0, 0, 16'h0000, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[11] = mk(1, 0, 16'h0100, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'h0000);
        vecs[12] = mk(1, 0, 16'h0100, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 1, 16'h0100);
        vecs[13] = mk(1, 0, 16'h0100, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 8'h00, 0, 16'h0000);

        // Reset state
        drive(0, 0, 16'h0, 8'h0, 0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
        chk("rst_vid_valid", 32'(bus.vid_valid), 32'd0);
        chk("rst_vid_overrun", 32'(bus.vid_overrun), 32'd0);
        chk("rst_vid_dout", 32'(bus.vid_dout), 32'd0);
        chk("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
        chk("rst_wait_idle", 32'(bus.cpu_wait_n), 32'd1);
        bus.cpu_req = 1'b1;
        #1;
        chk("rst_wait_follows_req", 32'(bus.cpu_wait_n), 32'd0);
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        next_cycle();

        // Table: isolated video fetch, CPU write, start of CPU read
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cdin, vecs[i].vreq, vecs[i].vaddr);
            @(negedge clk);
            chk($sformatf("vec%0d_wait_n", i), 32'(bus.cpu_wait_n), 32'(vecs[i].e_wait_n));
            chk($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_mem_we));
            chk($sformatf("vec%0d_vid_valid", i), 32'(bus.vid_valid), 32'(vecs[i].e_vvalid));
            if (vecs[i].chk_vdout)
                chk($sformatf("vec%0d_vid_dout", i), 32'(bus.vid_dout), 32'(vecs[i].e_vdout));
            if (vecs[i].chk_maddr)
                chk($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_maddr));
            if (vecs[i].chk_maddr && vecs[i].e_mem_we)
                chk($sformatf("vec%0d_mem_din", i), 32'(bus.mem_din), 32'(vecs[i].cdin));
            next_cycle();
        end
        chk("video_no_overrun", 32'(bus.vid_overrun), 32'd0);

        // Finish the read of 0x0100
        wait_cpu("rd_release", 4);
        chk("rd_cpu_dout", 32'(bus.cpu_dout), 32'h5A);
        drive(0, 0, 16'h0, 8'h0, 0, 16'h0);
        repeat (3) next_cycle();

        // Starvation guard: CPU read held against back-to-back video fetches
        vn = 0;
        vbefore = 0;
        cdone = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.vid_req  = (c == 0 || c == 1 || c == 4 || c == 7 || c == 10);
            bus.vid_addr = 16'h2000 + 16'(vn);
            if (bus.vid_req) vn++;
            bus.cpu_req  = (c >= 1) && !cdone;
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 16'h0100;
            @(negedge clk);
            if (bus.vid_valid) begin
                vseen.push_back(bus.vid_dout);
                if (!cdone) vbefore++;
            end
            if (bus.cpu_req && bus.cpu_wait_n && !cdone) begin
                cdone = 1'b1;
                chk("starve_cpu_dout", 32'(bus.cpu_dout), 32'h5A);
            end
            next_cycle();
        end
        drive(0, 0, 16'h0, 8'h0, 0, 16'h0);
        chk("starve_cpu_served", 32'(cdone), 32'd1);
        chk("starve_grants_before_cpu", 32'(vbefore), 32'd4);
        chk("starve_total_fetches", 32'(vseen.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < vseen.size())
                chk($sformatf("starve_fetch%0d", i), 32'(vseen[i]), 32'h10 + 32'(i));
        chk("starve_no_overrun", 32'(bus.vid_overrun), 32'd0);
        repeat (2) next_cycle();

        // Overrun: two fetch requests while the CPU read occupies the port
        vcnt = 0;
        for (int c = 0; c < 12; c++) begin
            bus.cpu_req  = (c < 3);
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 16'h0100;
            bus.vid_req  = (c == 1 || c == 2);
            bus.vid_addr = (c == 1) ? 16'h3000 : 16'h3001;
            @(negedge clk);
            if (bus.vid_valid) begin
                vcnt++;
                chk("ovr_vid_dout", 32'(bus.vid_dout), 32'h44);
            end
            next_cycle();
        end
        drive(0, 0, 16'h0, 8'h0, 0, 16'h0);
        chk("ovr_single_fetch", 32'(vcnt), 32'd1);
        chk("ovr_flag", 32'(bus.vid_overrun), 32'd1);

        // Abort: read dropped during CPU_A, then a fresh request
        drive(1, 0, 16'h4000, 8'h0, 0, 16'h0);
        next_cycle();
        bus.cpu_req = 1'b0;
        next_cycle();
        next_cycle();
        bus.cpu_req = 1'b1;
        @(negedge clk);
        chk("abort_wait_low", 32'(bus.cpu_wait_n), 32'd0);
        chk("abort_dout_captured", 32'(bus.cpu_dout), 32'h77);
        next_cycle();
        wait_cpu("abort_retry_release", 6);
        chk("abort_retry_dout", 32'(bus.cpu_dout), 32'h77);
        drive(0, 0, 16'h0, 8'h0, 0, 16'h0);
        repeat (2) next_cycle();

        // Reset during CPU_W
        drive(1, 1, 16'h5000, 8'h99, 0, 16'h0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_mem_we_before", 32'(bus.mem_we), 32'd1);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 16'h0, 8'h0, 0, 16'h0);
        @(negedge clk);
        chk("rstw_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rstw_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rstw_mem_din", 32'(bus.mem_din), 32'd0);
        chk("rstw_vid_overrun", 32'(bus.vid_overrun), 32'd0);
        chk("rstw_cpu_dout", 32'(bus.cpu_dout), 32'd0);
        chk("rstw_vid_dout", 32'(bus.vid_dout), 32'd0);
        chk("rstw_wait_n", 32'(bus.cpu_wait_n), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("rstw_idle_mem_we", 32'(bus.mem_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
